prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU instruction-memory interface. Receives a framed program image as a byte stream over a valid/ready handshake, typically from a UART receiver.
- Assembles 16-bit instruction words big-endian, writes them to consecutive instruction-memory addresses starting at 0, and verifies an XOR checksum.
- Holds the CPU in reset until the image is fully loaded and verified.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset; clock clk
- reload  input  1  single-cycle pulse; abort or restart a load and re-hold the CPU in reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte this cycle
- im_we  output  1  instruction-memory write enable (one-cycle pulse per word)
- im_addr  output  ADDR_W  instruction-memory write address
- im_wdata  output  16  instruction word to write
- cpu_nreset  output  1  CPU reset, active-low; 1 only in DONE
- done  output  1  image loaded and checksum OK
- error  output  1  length overflow or checksum mismatch
- words_loaded  output  ADDR_W+1  words written in the current load

Behaviour:
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count), then N words as HI byte then LO byte, then CHK.
  - CHK must equal the XOR of every preceding frame byte, including the length bytes.
- A byte transfers on a rising edge where in_valid=1 and in_ready=1. No transfer otherwise; in_data is ignored.
- States: S_LEN_HI, S_LEN_LO, S_WHI, S_WLO, S_WRITE, S_CHK, S_DONE, S_ERR.
- in_ready=1 in S_LEN_HI, S_LEN_LO, S_WHI, S_WLO and S_CHK; 0 in all other states.
- Reset: state S_LEN_HI, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_nreset=0, done=0, error=0, words_loaded=0, running XOR=0.
- Transitions:
  - S_LEN_HI: on transfer, store len[15:8] and go to S_LEN_LO.
  - S_LEN_LO: on transfer, store len[7:0]. If N > 2^ADDR_W, go to S_ERR. If N = 0, go to S_CHK. Otherwise go to S_WHI.
  - S_WHI: on transfer, latch the high byte and go to S_WLO.
  - S_WLO: on transfer, go to S_WRITE. Register im_wdata = {hi, byte} and im_addr = words_loaded[ADDR_W-1:0].
  - S_WRITE: lasts exactly one cycle with im_we=1 (registered, Moore). words_loaded increments at the end of the cycle. Next state is S_CHK if the new words_loaded equals N, else S_WHI.
  - S_CHK: on transfer, go to S_DONE if byte == XOR, else S_ERR.
  - S_DONE: cpu_nreset=1 and done=1 (registered, asserted the cycle after the CHK transfer). Holds until reload or reset.
  - S_ERR: error=1, cpu_nreset=0. Holds until reload or reset.
- The running XOR updates on every transfer except the CHK byte.
- Latency: the im_we pulse occurs exactly 1 cycle after the LO-byte transfer edge. Maximum throughput is one word per 3 cycles.
- Between im_we pulses, im_addr and im_wdata hold their last value. im_we is never asserted outside S_WRITE.
- reload=1 in any state: on the next edge, return to reset values (cpu_nreset=0, done=0, error=0, words_loaded=0, XOR=0, state S_LEN_HI).
  - reload has priority over a simultaneous byte transfer; that byte is dropped.
  - If reload coincides with S_WRITE, the im_we pulse in that cycle still completes. The reload takes effect on the edge that ends it.
- reset mid-load has the same effect as reload. Memory contents are not cleared.
- N = 2^ADDR_W is legal: the final write goes to address 2^ADDR_W-1 and words_loaded reaches 2^ADDR_W (hence the ADDR_W+1 width).

Test Plan:
- Basic load: bytes 00 02 12 34 AB CD, CHK=00^02^12^34^AB^CD=42 -> writes 0x1234@0, 0xABCD@1, one im_we pulse each. done=1, cpu_nreset=1, words_loaded=2.
- Bad checksum: same frame with CHK=43 -> both words written, then error=1, cpu_nreset=0, done=0, in_ready=0.
- Empty and overflow: 00 00 00 -> done=1, no im_we pulses. With ADDR_W=8, 01 01 -> S_ERR right after LEN_LO, error=1, no writes.
- Backpressure: in_valid held 1 continuously through the frame -> in_ready drops for exactly 1 cycle per word (S_WRITE), no byte lost or duplicated, im_we spacing >= 3 cycles. With in_valid gaps inserted, the state holds.
- Reload mid-load: after 00 03 11 22 33, assert reload together with a valid byte -> byte dropped, state S_LEN_HI, words_loaded=0. A fresh frame then loads from address 0 and reaches done.
- Full capacity: ADDR_W=4, N=16 words with a correct CHK -> last write to address 15, words_loaded=16, done=1. Assert reset while in S_DONE -> cpu_nreset=0 and done=0 on the next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: writer side of the CPU instruction-memory interface.
// Accepts a framed program image as a byte stream over valid/ready:
//   LEN_HI, LEN_LO (word count N), N x {HI, LO} words, CHK.
// Words are written big-endian to consecutive addresses starting at 0.
// CHK must equal the XOR of every preceding frame byte. The CPU is held
// in reset until the image is fully loaded and verified.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   reload          one-cycle pulse; abort/restart load, re-hold the CPU
//   in_data/valid   incoming byte stream
//   in_ready        loader accepts a byte this cycle
//   im_we/addr/wdata instruction-memory write port (one pulse per word)
//   cpu_nreset      active-low CPU reset, released only when done
//   done / error    load verified / overflow or checksum mismatch
//   words_loaded    words written in the current load
//
// state    | meaning
// S_LEN_HI | waiting for length high byte
// S_LEN_LO | waiting for length low byte
// S_WHI    | waiting for word high byte
// S_WLO    | waiting for word low byte
// S_WRITE  | one-cycle memory write, stream stalled
// S_CHK    | waiting for checksum byte
// S_DONE   | image verified, CPU released
// S_ERR    | overflow or checksum mismatch
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_nreset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_WHI,
    S_WLO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // 17 bits so that ADDR_W = 16 still gives a representable capacity.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t          state, state_nxt;
  logic [15:0]     len;
  logic [7:0]      hi_byte;
  logic [7:0]      xor_acc;
  logic            xfer;
  logic [15:0]     len_new;
  logic [ADDR_W:0] wl_inc;
  logic            last_word;

  assign xfer      = in_valid && in_ready;
  assign len_new   = {len[15:8], in_data};
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = (17'(wl_inc) == {1'b0, len});

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_WHI, S_WLO, S_CHK: in_ready = 1'b1;
      default:                                 in_ready = 1'b0;
    endcase

    // reload wins over any byte offered in the same cycle
    if (reload) begin
      state_nxt = S_LEN_HI;
    end else begin
      case (state)
        S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if (xfer) begin
            if ({1'b0, len_new} > CAPACITY) state_nxt = S_ERR;
            else if (len_new == 16'd0)      state_nxt = S_CHK;
            else                            state_nxt = S_WHI;
          end
        end
        S_WHI:   if (xfer) state_nxt = S_WLO;
        S_WLO:   if (xfer) state_nxt = S_WRITE;
        S_WRITE: state_nxt = last_word ? S_CHK : S_WHI;
        S_CHK: begin
          if (xfer) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Status outputs are flops loaded from the next state, so they change
  // on the same edge as the state itself. im_addr/im_wdata keep their
  // last value across a reload; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_nreset   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      hi_byte      <= '0;
      xor_acc      <= '0;
    end else begin
      im_we      <= (state_nxt == S_WRITE);
      done       <= (state_nxt == S_DONE);
      cpu_nreset <= (state_nxt == S_DONE);
      error      <= (state_nxt == S_ERR);
      if (reload) begin
        words_loaded <= '0;
        len          <= '0;
        xor_acc      <= '0;
      end else begin
        if (xfer && state != S_CHK) xor_acc <= xor_acc ^ in_data;
        case (state)
          S_LEN_HI: if (xfer) len[15:8] <= in_data;
          S_LEN_LO: if (xfer) len[7:0] <= in_data;
          S_WHI:    if (xfer) hi_byte <= in_data;
          S_WLO: begin
            if (xfer) begin
              im_wdata <= {hi_byte, in_data};
              im_addr  <= words_loaded[ADDR_W-1:0];
            end
          end
          S_WRITE:  words_loaded <= wl_inc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reload = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [15:0]   im_wdata;
  logic          cpu_nreset;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    frame[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  int cyc = 0;
  int last_we = -1;
  int min_gap = 1000;
  int we_ready_viol = 0;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .reload(reload),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_nreset(cpu_nreset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // write monitor: records every im_we pulse and the spacing between them
  initial forever begin
    @(negedge clk);
    if (im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
      if (last_we >= 0 && (cyc - last_we) < min_gap) min_gap = cyc - last_we;
      last_we = cyc;
      if (in_ready) we_ready_viol++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    last_we = -1;
    min_gap = 1000;
  endtask

  task automatic build(input int n, input bit corrupt);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    if (corrupt) x ^= 8'(1 << $urandom_range(7));
    frame.push_back(x);
  endtask

  task automatic build_ovf(input int n);
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < 4; i++) frame.push_back(8'($urandom));
  endtask

  // Drives frame[] with random valid gaps; stops once the frame is
  // consumed or the loader has reached a terminal status.
  task automatic run_frame(input int gap_pct, output int cycles, output int consumed);
    int idx;
    int n;
    bit take;
    idx = 0;
    n = 0;
    while (idx < frame.size() && !done && !error && n < 3000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? frame[idx] : 8'($urandom);
      take = in_valid && in_ready;
      step();
      n++;
      if (take) idx++;
    end
    in_valid = 1'b0;
    cycles = n;
    consumed = idx;
  endtask

  // Reference: outcome of a frame computed directly from the frame rules.
  task automatic check_frame(input string tag, input int consumed);
    int  nw;
    bit  ovf;
    bit  ok;
    int  exp_w;
    logic [7:0] x;
    nw  = {frame[0], frame[1]};
    ovf = nw > (1 << AW);
    ok  = 1'b0;
    if (!ovf) begin
      x = 8'h00;
      for (int i = 0; i < 2 + 2 * nw; i++) x ^= frame[i];
      ok = (frame[2 + 2 * nw] == x);
    end
    exp_w = ovf ? 0 : nw;
    chk($sformatf("%s_consumed", tag), consumed, ovf ? 2 : frame.size());
    chk($sformatf("%s_done", tag), done, ok);
    chk($sformatf("%s_error", tag), error, !ok);
    chk($sformatf("%s_cpu_nreset", tag), cpu_nreset, ok);
    chk($sformatf("%s_in_ready", tag), in_ready, 0);
    chk($sformatf("%s_words_loaded", tag), words_loaded, exp_w);
    chk($sformatf("%s_nwrites", tag), wr_addr_q.size(), exp_w);
    for (int i = 0; i < wr_addr_q.size() && i < exp_w; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], {frame[2 + 2 * i], frame[3 + 2 * i]});
    end
    chk($sformatf("%s_we_vs_ready", tag), we_ready_viol, 0);
  endtask

  initial begin
    int cycles;
    int consumed;
    int n;

    repeat (3) step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_cpu_nreset", cpu_nreset, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);

    // basic load, continuous valid
    clear_mon();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_frame(0, cycles, consumed);
    check_frame("basic", consumed);
    chk("basic_cycles", cycles, 9);
    chk("basic_we_gap", min_gap, 3);

    // bad checksum
    pulse_reload();
    chk("reload_from_done", done, 0);
    clear_mon();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    run_frame(0, cycles, consumed);
    check_frame("badchk", consumed);

    // empty image
    pulse_reload();
    chk("reload_from_err", error, 0);
    clear_mon();
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(0, cycles, consumed);
    check_frame("empty", consumed);
    chk("empty_cycles", cycles, 3);

    // overflow: 257 and 17 (one past capacity)
    pulse_reload();
    clear_mon();
    frame = '{8'h01, 8'h01, 8'h00, 8'h00};
    run_frame(0, cycles, consumed);
    check_frame("ovf257", consumed);
    pulse_reload();
    clear_mon();
    build_ovf((1 << AW) + 1);
    run_frame(0, cycles, consumed);
    check_frame("ovf17", consumed);

    // full capacity
    pulse_reload();
    clear_mon();
    build(1 << AW, 1'b0);
    run_frame(0, cycles, consumed);
    check_frame("full", consumed);
    chk("full_cycles", cycles, 3 * (1 << AW) + 3);
    chk("full_we_gap", min_gap, 3);

    // reset while done
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_done_cpu_nreset", cpu_nreset, 0);
    chk("rst_done_done", done, 0);
    chk("rst_done_words", words_loaded, 0);
    chk("rst_done_in_ready", in_ready, 1);

    // reload mid-load with a simultaneous valid byte
    clear_mon();
    frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    run_frame(0, cycles, consumed);
    chk("midload_words_before", words_loaded, 1);
    in_valid = 1'b1;
    in_data  = 8'h44;
    reload   = 1'b1;
    step();
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("midload_words", words_loaded, 0);
    chk("midload_in_ready", in_ready, 1);
    chk("midload_nwrites", wr_addr_q.size(), 1);
    clear_mon();
    build(3, 1'b0);
    run_frame(0, cycles, consumed);
    check_frame("after_reload", consumed);

    // reload landing in the write cycle: pulse still completes
    pulse_reload();
    clear_mon();
    frame = '{8'h00, 8'h02, 8'hAA, 8'hBB};
    run_frame(0, cycles, consumed);
    chk("wr_reload_im_we", im_we, 1);
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("wr_reload_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() > 0) chk("wr_reload_data", wr_data_q[0], 16'hAABB);
    chk("wr_reload_words", words_loaded, 0);
    chk("wr_reload_in_ready", in_ready, 1);
    chk("wr_reload_im_we_after", im_we, 0);

    // randomized frames with valid gaps
    for (int t = 0; t < 24; t++) begin
      pulse_reload();
      chk($sformatf("rnd%0d_ready_after_reload", t), in_ready, 1);
      clear_mon();
      if ($urandom_range(5) == 0) begin
        n = $urandom_range(65535, (1 << AW) + 1);
        build_ovf(n);
      end else begin
        n = $urandom_range(1 << AW);
        build(n, $urandom_range(3) == 0);
      end
      run_frame($urandom_range(60), cycles, consumed);
      check_frame($sformatf("rnd%0d", t), consumed);
      if (min_gap != 1000) chk($sformatf("rnd%0d_gap_ok", t), min_gap >= 3, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
